mem_store_buffer: RTL and testbench
===================================

Name: mem_store_buffer

Overview:
- Posted-write store buffer between the processor's memory stage and a slower data RAM with a req/ack handshake.
- Accepts word and byte stores (sw/sb) in one cycle and drains them in order to the RAM.
- Forwards buffered word-store data to same-cycle loads.
- Requests a stall when a load hits a pending byte store.

Parameters:
DEPTH, 4, number of buffered stores (power of two, ≥2)
CNT_W, 3, width of count output (clog2(DEPTH)+1)

Ports:
clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
st_valid  in  1  store request from memory stage (Mem_WrEn)
st_byte  in  1  1 = sb (single byte), 0 = sw (full word)
st_addr  in  32  store byte address (ALU_MEM_Addr)
st_data  in  32  store data; sb uses [7:0]
st_ready  out  1  buffer can accept a store this cycle
ld_valid  in  1  load lookup valid
ld_addr  in  32  load byte address
ld_hit  out  1  load word-address matches a buffered word store
ld_data  out  32  forwarded data when ld_hit
ld_stall  out  1  load matches a buffered byte store; processor holds PC
mem_req  out  1  write request to data RAM
mem_addr  out  32  word-aligned RAM address
mem_wdata  out  32  RAM write data
mem_be  out  4  byte enables
mem_ack  in  1  RAM write accepted
count  out  CNT_W  occupied entries
empty  out  1  count == 0

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named Reset.
- Reset: pointers=0, count=0, state IDLE, mem_req=0, mem_addr=0, mem_wdata=0, mem_be=0. Reset during a pending request drops it, discards all entries, and ignores any later ack.
- Entry: {valid, byte, addr[31:2], lane addr[1:0], data}.
- Enqueue: occurs when st_valid && st_ready at the clk edge.
  - st_ready = (count < DEPTH), computed from the pre-edge count.
  - A store arriving while full is dropped with no state change.
  - No bypass: the entry is visible from the next cycle.
- RAM encoding:
  - sw: mem_addr = {addr[31:2],2'b00}, mem_be = 4'hF, mem_wdata = data.
  - sb: mem_be = 4'b0001 << lane, mem_wdata = {4{data[7:0]}}.
- Drain FSM has two states:
  - IDLE: if count != 0, register the head fields onto the mem_* outputs, set mem_req=1, go to REQ.
  - REQ: mem_req and all mem_* outputs stay stable until mem_ack. On mem_ack: pop head, mem_req=0, go to IDLE.
  - One bubble cycle between consecutive requests (ack → IDLE → REQ).
  - mem_ack in IDLE is ignored.
- Simultaneous enqueue and pop: count unchanged, both pointers advance. When full, st_ready=0 even if a pop occurs that same cycle.
- The head entry stays in the buffer (and forwardable) until its ack.
- Forwarding is combinational:
  - Search all valid entries for addr[31:2] == ld_addr[31:2]; the youngest match wins.
  - Youngest match is a word store: ld_hit=1, ld_data = entry data.
  - Youngest match is a byte store: ld_stall=1, ld_hit=0.
  - No match, or ld_valid=0: ld_hit=0, ld_stall=0, ld_data=0.
- Pointer wrap: modulo DEPTH. count is in the range 0..DEPTH. empty = (count == 0).

Test Plan:
1. Reset; sw addr 0x00000010 data 0xDEADBEEF; ack 3 cycles after mem_req -> mem_req rises the cycle after enqueue; addr 0x10, be 0xF, wdata 0xDEADBEEF held until ack; then count=0, empty=1, mem_req=0.
2. Five back-to-back sw to 0x0,0x4,0x8,0xC,0x10 with ack low -> st_ready=0 after the 4th; 5th dropped; count=4. Then ack each -> RAM sees 0x0,0x4,0x8,0xC in order with a one-cycle gap between requests.
3. sb addr 0x13 data 0x000000AB -> mem_addr 0x10, mem_be 4'b1000, mem_wdata 0xABABABAB.
4. sw 0x20=0x1111, sw 0x20=0x2222, ack held low; load 0x22 -> ld_hit=1, ld_data=0x00002222. Load 0x24 -> ld_hit=0, ld_stall=0.
5. sb 0x30 data 0x5A, then load 0x31 -> ld_stall=1 until the cycle after that entry's ack, then ld_stall=0.
6. Three entries queued, in REQ; assert Reset one cycle -> next cycle mem_req=0, count=0, empty=1. A subsequent mem_ack pulse causes no change.

Source files
------------

// File: rtl/mem_store_buffer_if.sv
// Write-only RAM port of the store buffer.
// req/ack handshake; address is always word aligned.
interface mem_store_buffer_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  modport master (
    output mem_req, mem_addr, mem_wdata, mem_be,
    input  mem_ack
  );

  modport slave (
    input  mem_req, mem_addr, mem_wdata, mem_be,
    output mem_ack
  );
endinterface

// File: rtl/mem_store_buffer.sv
// Posted-write store buffer: in-order drain to RAM,
// word-store forwarding and byte-store load stall.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             st_valid,
  input  logic             st_byte,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  output logic             st_ready,
  input  logic             ld_valid,
  input  logic [31:0]      ld_addr,
  output logic             ld_hit,
  output logic [31:0]      ld_data,
  output logic             ld_stall,
  mem_store_buffer_if.master mem,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  logic [29:0]      r_waddr [DEPTH];
  logic [1:0]       r_lane  [DEPTH];
  logic [31:0]      r_data  [DEPTH];
  logic             r_byte  [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_cnt;

  state_t           r_state;
  state_t           w_nxt;
  logic             w_load;
  logic             w_pop;
  logic             w_push;

  logic             r_req;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;

  logic             w_fhit;
  logic             w_fbyte;
  logic [31:0]      w_fdata;
  logic [PTR_W-1:0] w_idx;

  assign st_ready = (r_cnt < CNT_W'(DEPTH));
  assign w_push   = st_valid & st_ready;
  assign count    = r_cnt;
  assign empty    = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_waddr[r_wp] <= st_addr[31:2];
        r_lane[r_wp]  <= st_addr[1:0];
        r_data[r_wp]  <= st_data;
        r_byte[r_wp]  <= st_byte;
        r_wp          <= r_wp + PTR_W'(1);
      end
      if (w_pop)
        r_rp <= r_rp + PTR_W'(1);
      unique case (1'b1)
        (w_push & ~w_pop): r_cnt <= r_cnt + CNT_W'(1);
        (~w_push & w_pop): r_cnt <= r_cnt - CNT_W'(1);
        default:           r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt  = r_state;
    w_load = 1'b0;
    w_pop  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_cnt != '0) begin
          w_load = 1'b1;
          w_nxt  = REQ;
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          w_pop = 1'b1;
          w_nxt = IDLE;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  // Bus fields are latched once per request and held until ack
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_load) begin
      r_req  <= 1'b1;
      r_addr <= {r_waddr[r_rp], 2'b00};
      if (r_byte[r_rp]) begin
        r_be    <= 4'b0001 << r_lane[r_rp];
        r_wdata <= {4{r_data[r_rp][7:0]}};
      end else begin
        r_be    <= 4'hF;
        r_wdata <= r_data[r_rp];
      end
    end else if (w_pop) begin
      r_req <= 1'b0;
    end
  end

  assign mem.mem_req   = r_req;
  assign mem.mem_addr  = r_addr;
  assign mem.mem_wdata = r_wdata;
  assign mem.mem_be    = r_be;

  // Walk oldest to youngest so the last match wins
  always_comb begin
    w_fhit  = 1'b0;
    w_fbyte = 1'b0;
    w_fdata = '0;
    w_idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rp + PTR_W'(k);
      if ((CNT_W'(k) < r_cnt) &&
          (r_waddr[w_idx] == ld_addr[31:2])) begin
        w_fhit  = 1'b1;
        w_fbyte = r_byte[w_idx];
        w_fdata = r_data[w_idx];
      end
    end
  end

  assign ld_hit   = ld_valid & w_fhit & ~w_fbyte;
  assign ld_stall = ld_valid & w_fhit & w_fbyte;
  assign ld_data  = ld_hit ? w_fdata : 32'h0;

endmodule

// File: tb/tb_mem_store_buffer.sv
// Directed bench for mem_store_buffer with a
// scoreboard queue of expected RAM writes.
module tb_mem_store_buffer;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_byte = 1'b0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        st_ready;
  logic        ld_valid = 1'b0;
  logic [31:0] ld_addr = '0;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        ld_stall;
  logic [2:0]  count;
  logic        empty;

  mem_store_buffer_if mif();

  mem_store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .st_valid (st_valid),
    .st_byte  (st_byte),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_hit   (ld_hit),
    .ld_data  (ld_data),
    .ld_stall (ld_stall),
    .mem      (mif.master),
    .count    (count),
    .empty    (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic store(bit b, logic [31:0] a, logic [31:0] d, bit acc);
    exp_t e;
    st_valid = 1'b1;
    st_byte  = b;
    st_addr  = a;
    st_data  = d;
    #1;
    chk("st_ready", {31'b0, st_ready}, {31'b0, acc});
    if (acc) begin
      e.a  = {a[31:2], 2'b00};
      e.be = b ? (4'b0001 << a[1:0]) : 4'hF;
      e.d  = b ? {4{d[7:0]}} : d;
      q.push_back(e);
    end
    step();
    st_valid = 1'b0;
  endtask

  task automatic ram_ack(int hold);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mif.mem_req === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("req_seen", {31'b0, got}, 32'd1);
    if (!got) return;
    if (q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL sb_underflow observed=req expected=none");
      return;
    end
    e = q.pop_front();
    for (int c = 0; c <= hold; c++) begin
      chk("mem_addr", mif.mem_addr, e.a);
      chk("mem_be", {28'b0, mif.mem_be}, {28'b0, e.be});
      chk("mem_wdata", mif.mem_wdata, e.d);
      chk("mem_req_hold", {31'b0, mif.mem_req}, 32'd1);
      if (c < hold) step();
    end
    mif.mem_ack = 1'b1;
    step();
    mif.mem_ack = 1'b0;
    chk("req_drop", {31'b0, mif.mem_req}, 32'd0);
  endtask

  initial begin
    mif.mem_ack = 1'b0;
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_req", {31'b0, mif.mem_req}, 32'd0);
    chk("rst_addr", mif.mem_addr, 32'd0);
    chk("rst_be", {28'b0, mif.mem_be}, 32'd0);

    // 1: single word store, slow ack
    store(1'b0, 32'h10, 32'hDEADBEEF, 1'b1);
    chk("t1_req_lag", {31'b0, mif.mem_req}, 32'd0);
    chk("t1_count", {29'b0, count}, 32'd1);
    step();
    chk("t1_req_rise", {31'b0, mif.mem_req}, 32'd1);
    ram_ack(3);
    chk("t1_count0", {29'b0, count}, 32'd0);
    chk("t1_empty", {31'b0, empty}, 32'd1);

    // 2: overfill then drain in order
    store(1'b0, 32'h0, 32'h100, 1'b1);
    store(1'b0, 32'h4, 32'h104, 1'b1);
    store(1'b0, 32'h8, 32'h108, 1'b1);
    store(1'b0, 32'hC, 32'h10C, 1'b1);
    store(1'b0, 32'h10, 32'h110, 1'b0);
    chk("t2_full", {29'b0, count}, 32'd4);
    for (int i = 0; i < 4; i++) ram_ack(0);
    chk("t2_empty", {31'b0, empty}, 32'd1);

    // 3: byte store lane 3
    store(1'b1, 32'h13, 32'h000000AB, 1'b1);
    ram_ack(1);

    // 4: youngest word store forwards
    store(1'b0, 32'h20, 32'h1111, 1'b1);
    store(1'b0, 32'h20, 32'h2222, 1'b1);
    ld_valid = 1'b1;
    ld_addr  = 32'h22;
    #1;
    chk("t4_hit", {31'b0, ld_hit}, 32'd1);
    chk("t4_data", ld_data, 32'h2222);
    chk("t4_nostall", {31'b0, ld_stall}, 32'd0);
    ld_addr = 32'h24;
    #1;
    chk("t4_miss_hit", {31'b0, ld_hit}, 32'd0);
    chk("t4_miss_stall", {31'b0, ld_stall}, 32'd0);
    chk("t4_miss_data", ld_data, 32'd0);
    ld_valid = 1'b0;
    ram_ack(0);
    ram_ack(0);

    // 5: byte store blocks load until its ack
    store(1'b1, 32'h30, 32'h5A, 1'b1);
    ld_valid = 1'b1;
    ld_addr  = 32'h31;
    #1;
    chk("t5_stall", {31'b0, ld_stall}, 32'd1);
    chk("t5_nohit", {31'b0, ld_hit}, 32'd0);
    ram_ack(2);
    chk("t5_stall_clr", {31'b0, ld_stall}, 32'd0);
    ld_valid = 1'b0;

    // 6: reset while a request is pending
    store(1'b0, 32'h40, 32'h40, 1'b1);
    store(1'b0, 32'h44, 32'h44, 1'b1);
    store(1'b0, 32'h48, 32'h48, 1'b1);
    chk("t6_req", {31'b0, mif.mem_req}, 32'd1);
    chk("t6_count", {29'b0, count}, 32'd3);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    q.delete();
    chk("t6_req0", {31'b0, mif.mem_req}, 32'd0);
    chk("t6_count0", {29'b0, count}, 32'd0);
    chk("t6_empty", {31'b0, empty}, 32'd1);
    chk("t6_addr0", mif.mem_addr, 32'd0);
    mif.mem_ack = 1'b1;
    step();
    mif.mem_ack = 1'b0;
    chk("t6_ack_cnt", {29'b0, count}, 32'd0);
    chk("t6_ack_req", {31'b0, mif.mem_req}, 32'd0);
    step();
    chk("t6_idle_req", {31'b0, mif.mem_req}, 32'd0);
    chk("t6_ready", {31'b0, st_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
